// File: rtl/data_memory_pipe.sv
// Fixed-latency line memory with request/ack handshake, self-clearing after reset,
// byte-masked writes and an error completion for out-of-range line indices.
module data_memory_pipe #(
   parameter int DATA_WIDTH = 256,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 10,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    enable_i,
   input  logic                    write_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   data_i,
   output logic [DATA_WIDTH-1:0]   data_o,
   output logic                    ack_o,
   output logic                    err_o,
   output logic                    busy_o
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFS   = $clog2(BYTES);
   localparam int IDXW  = $clog2(DEPTH);
   localparam int CW    = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_ACK} state_t;

   state_t                  state_q, state_d;
   logic [IDXW-1:0]         init_q, init_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;

   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    wr_q;
   logic [BYTES-1:0]        be_q;
   logic [DATA_WIDTH-1:0]   wdat_q;
   logic                    latch_req;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic                    mem_we;
   logic [IDXW-1:0]         mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;

   logic [ADDR_WIDTH-1:0]   line_addr;
   logic [IDXW-1:0]         req_idx;
   logic                    req_oor;
   logic [DATA_WIDTH-1:0]   rd_line;
   logic [DATA_WIDTH-1:0]   merged;

   // Range check uses the full shifted address so large addresses never alias.
   assign line_addr = addr_q >> OFS;
   assign req_idx   = line_addr[IDXW-1:0];
   assign req_oor   = (line_addr >> IDXW) != '0;
   assign rd_line   = mem_q[req_idx];

   always_comb begin
      merged = rd_line;
      for (int unsigned b = 0; b < BYTES; b++) begin
         if (be_q[b]) merged[8*b +: 8] = wdat_q[8*b +: 8];
      end
   end

   always_comb begin
      state_d   = state_q;
      init_d    = init_q;
      cnt_d     = cnt_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      data_d    = '0;
      latch_req = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = req_idx;
      mem_wdata = merged;
      case (state_q)
         S_INIT: begin
            mem_we    = 1'b1;
            mem_waddr = init_q;
            mem_wdata = '0;
            init_d    = init_q + IDXW'(1);
            if (init_q == IDXW'(DEPTH - 1)) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (enable_i) begin
               latch_req = 1'b1;
               cnt_d     = CW'(LATENCY - 1);
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d = S_ACK;
               ack_d   = 1'b1;
               if (req_oor) begin
                  err_d = 1'b1;
               end else if (wr_q) begin
                  mem_we = 1'b1;
                  data_d = merged;
               end else begin
                  data_d = rd_line;
               end
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_INIT;
         init_q  <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         init_q  <= init_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   // Request capture and storage carry no reset; INIT clears the array itself.
   always_ff @(posedge clk_i) begin
      if (rst_i && latch_req) begin
         addr_q <= addr_i;
         wr_q   <= write_i;
         be_q   <= be_i;
         wdat_q <= data_i;
      end
      if (rst_i && mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign data_o = data_q;
   assign ack_o  = ack_q;
   assign err_o  = err_q;
   assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed, table-driven bench for data_memory_pipe (DEPTH=16, LATENCY=3, 256-bit lines).
module tb_data_memory_pipe;

   localparam int DW    = 256;
   localparam int DEPTH = 16;
   localparam int LAT   = 3;
   localparam int AW    = 32;
   localparam int BW    = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] addr;
   logic          en;
   logic          wr;
   logic [BW-1:0] be;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          ack;
   logic          err;
   logic          busy;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   data_memory_pipe #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH),
      .LATENCY   (LAT),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .addr_i  (addr),
      .enable_i(en),
      .write_i (wr),
      .be_i    (be),
      .data_i  (din),
      .data_o  (dout),
      .ack_o   (ack),
      .err_o   (err),
      .busy_o  (busy)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic          w;
      logic [BW-1:0] b;
      logic [DW-1:0] d;
      logic [DW-1:0] exp_d;
      logic          exp_e;
   } vec_t;

   vec_t          vecs [10];
   logic [DW-1:0] model [DEPTH];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", DW'(busy), '0);
   endtask

   // Counts edges from reset release until busy drops, and any acks seen meanwhile.
   task automatic measure_init(output int cycles, output int acks);
      cycles = 0;
      acks   = 0;
      while (busy && cycles < 100) begin
         @(posedge clk); @(negedge clk);
         cycles++;
         if (ack) acks++;
      end
   endtask

   task automatic xact(input logic [AW-1:0] a, input logic w, input logic [BW-1:0] b,
                       input logic [DW-1:0] d, output logic [DW-1:0] rd,
                       output logic er, output int lat);
      wait_idle();
      addr = a; wr = w; be = b; din = d; en = 1'b1;
      @(posedge clk); @(negedge clk);
      en   = 1'b0;
      addr = $urandom;
      wr   = ~w;
      be   = ~b;
      din  = {8{$urandom}};
      lat  = -1;
      rd   = '0;
      er   = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); @(negedge clk);
         if (ack) begin
            lat = n;
            rd  = dout;
            er  = err;
            break;
         end
      end
      if (lat > 0) begin
         @(posedge clk); @(negedge clk);
         chk("post_ack", {dout[DW-3:0], ack, err}, '0);
      end
   endtask

   task automatic run(input string name, input logic [AW-1:0] a, input logic w,
                      input logic [BW-1:0] b, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp_d, input logic exp_e);
      logic [DW-1:0] rd;
      logic          er;
      int            lat;
      xact(a, w, b, d, rd, er, lat);
      chk({name, "_lat"}, DW'(lat), DW'(LAT));
      chk({name, "_data"}, rd, exp_d);
      chk({name, "_err"}, DW'(er), DW'(exp_e));
   endtask

   initial begin
      int            cyc, nacks, t1, t2, c;
      logic [DW-1:0] a5, x11, ff, mixed;

      a5    = {32{8'hA5}};
      x11   = {32{8'h11}};
      ff    = '1;
      mixed = {x11[DW-1:8], 8'hFF};

      vecs[0] = '{32'h040, 1'b1, '1,         a5, a5,    1'b0};
      vecs[1] = '{32'h040, 1'b0, '0,         ff, a5,    1'b0};
      vecs[2] = '{32'h0A0, 1'b1, '1,         x11, x11,  1'b0};
      vecs[3] = '{32'h0A0, 1'b1, BW'(1),     ff, mixed, 1'b0};
      vecs[4] = '{32'h0A0, 1'b0, '1,         '0, mixed, 1'b0};
      vecs[5] = '{32'h200, 1'b0, '1,         '0, '0,    1'b1};
      vecs[6] = '{32'h200, 1'b1, '1,         ff, '0,    1'b1};
      vecs[7] = '{32'h060, 1'b1, '0,         ff, '0,    1'b0};
      vecs[8] = '{32'h05F, 1'b0, '0,         '0, a5,    1'b0};
      vecs[9] = '{32'h1E0, 1'b0, '0,         '0, '0,    1'b0};

      rst = 1'b0; en = 1'b0; wr = 1'b0; be = '0; din = '0; addr = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", DW'(busy), DW'(1));
      chk("rst_outs", {dout[DW-3:0], ack, err}, '0);
      rst = 1'b1;
      measure_init(cyc, nacks);
      chk("init_cycles", DW'(cyc), DW'(DEPTH));
      chk("init_acks", DW'(nacks), '0);

      for (int i = 0; i < DEPTH; i++) run("init_rd", AW'(i * BW), 1'b0, '0, '0, '0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         run($sformatf("vec%0d", i), vecs[i].a, vecs[i].w, vecs[i].b, vecs[i].d,
             vecs[i].exp_d, vecs[i].exp_e);
         if (vecs[i].w && !vecs[i].exp_e) model[vecs[i].a[8:5]] = vecs[i].exp_d;
      end

      for (int i = 0; i < DEPTH; i++) run($sformatf("sweep%0d", i), AW'(i * BW), 1'b0, '0, '0, model[i], 1'b0);

      // Enable held through ACK and the following IDLE: exactly two back-to-back requests.
      wait_idle();
      addr = 32'h040; wr = 1'b0; be = '0; en = 1'b1;
      nacks = 0; t1 = 0; t2 = 0;
      for (c = 1; c <= 30; c++) begin
         @(posedge clk); @(negedge clk);
         if (ack) begin
            nacks++;
            if (nacks == 1) t1 = c;
            else t2 = c;
         end
         if (nacks == 1 && c == t1 + 2) en = 1'b0;
      end
      en = 1'b0;
      chk("hs_acks", DW'(nacks), DW'(2));
      chk("hs_gap", DW'(t2 - t1), DW'(LAT + 2));

      // Reset during WAIT of a write to line 3.
      wait_idle();
      addr = 32'h060; wr = 1'b1; be = '1; din = ff; en = 1'b1;
      @(posedge clk); @(negedge clk);
      en = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("midrst_ack", DW'(ack), '0);
      chk("midrst_busy", DW'(busy), DW'(1));
      rst = 1'b1;
      measure_init(cyc, nacks);
      chk("midrst_init_cycles", DW'(cyc), DW'(DEPTH));
      chk("midrst_acks", DW'(nacks), '0);
      run("midrst_line3", 32'h060, 1'b0, '0, '0, '0, 1'b0);
      run("midrst_line2", 32'h040, 1'b0, '0, '0, '0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
